// File: rtl/dmem_port_arbiter_if.sv
// Bundled port-B traffic for the data-memory arbiter: core MEM-stage side,
// host loader/debug side and the BRAM port B pins.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    // Core (MEM stage) side
    logic              core_req;
    logic [3:0]        core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [31:0]       core_wdata;
    logic              core_stall;
    logic [31:0]       core_rdata;

    // Host loader/debug side
    logic              host_valid;
    logic              host_write;
    logic [ADDR_W-1:0] host_addr;
    logic [3:0]        host_be;
    logic [31:0]       host_wdata;
    logic              host_ready;
    logic              host_rvalid;
    logic [31:0]       host_rdata;

    // BRAM port B
    logic [3:0]        bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_di;
    logic [31:0]       bram_do;

    // The arbiter itself
    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_stall, core_rdata,
        input  host_valid, host_write, host_addr, host_be, host_wdata,
        output host_ready, host_rvalid, host_rdata,
        output bram_we, bram_addr, bram_di,
        input  bram_do
    );

    // The surrounding pipeline, host and BRAM
    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_stall, core_rdata,
        output host_valid, host_write, host_addr, host_be, host_wdata,
        input  host_ready, host_rvalid, host_rdata,
        input  bram_we, bram_addr, bram_di,
        output bram_do
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares data-memory BRAM port B between the core MEM stage (priority) and a
// host master, with a starvation counter that forces one host slot.
module dmem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_port_arbiter_if.slave   bus
);
    localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  starve_cnt_reg, starve_cnt_next;
    logic              host_rvalid_reg;
    logic [31:0]       host_rdata_reg;

    logic              host_gnt;
    logic              core_gnt;
    logic [3:0]        we_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic [31:0]       di_mux;

    // Grant. Host is masked while rst is high so nothing is accepted during reset.
    always_comb begin
        host_gnt = 1'b0;
        core_gnt = 1'b0;
        if (!rst && bus.host_valid && (state_reg == IDLE) &&
            (!bus.core_req || (starve_cnt_reg == STARVE_LIM))) begin
            host_gnt = 1'b1;
        end
        core_gnt = bus.core_req & ~host_gnt;
    end

    // Port B mux; address/data default to the core fields when idle.
    always_comb begin
        we_mux   = 4'b0000;
        addr_mux = bus.core_addr;
        di_mux   = bus.core_wdata;
        if (host_gnt) begin
            we_mux   = bus.host_write ? bus.host_be : 4'b0000;
            addr_mux = bus.host_addr;
            di_mux   = bus.host_wdata;
        end else if (core_gnt) begin
            we_mux   = bus.core_we;
        end
    end

    // Next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (host_gnt && !bus.host_write) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counts cycles the waiting host lost to the core; saturates at the limit.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (host_gnt || !bus.host_valid) begin
            starve_cnt_next = '0;
        end else if (core_gnt && (state_reg == IDLE) &&
                     (starve_cnt_reg != STARVE_LIM)) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            starve_cnt_reg  <= '0;
            host_rvalid_reg <= 1'b0;
            host_rdata_reg  <= 32'h0;
        end else begin
            state_reg       <= state_next;
            starve_cnt_reg  <= starve_cnt_next;
            host_rvalid_reg <= (state_reg == RD_WAIT);
            // bram_do in RD_WAIT carries the host's word; later core loads may overwrite it
            if (state_reg == RD_WAIT) begin
                host_rdata_reg <= bus.bram_do;
            end
        end
    end

    assign bus.bram_we     = we_mux;
    assign bus.bram_addr   = addr_mux;
    assign bus.bram_di     = di_mux;
    assign bus.core_stall  = bus.core_req & host_gnt;
    assign bus.core_rdata  = bus.bram_do;
    assign bus.host_ready  = host_gnt;
    assign bus.host_rvalid = host_rvalid_reg;
    assign bus.host_rdata  = host_rdata_reg;

    a_grant_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(host_gnt && core_gnt));
    a_cnt_bounded: assert property (@(posedge clk) disable iff (rst)
        starve_cnt_reg <= STARVE_LIM);
    a_rd_wait_then_rvalid: assert property (@(posedge clk) disable iff (rst)
        (state_reg == RD_WAIT) |=> host_rvalid_reg);

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares BRAM port B (data memory) between two requesters: the pipeline MEM stage (core) and a host-side loader/debug master (host). The core has priority. A starvation counter forces a single host slot after STARVE_MAX cycles of contention, stalling the core for exactly that cycle. The block sits between the MEM/WB stages and the dual-port BRAM; port A (IMEM) is untouched.

## Interface
Parameters:
- ADDR_W, 32, byte address width on all address ports
- STARVE_MAX, 8, contended cycles after which the host is forced a slot (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- core_req  in  1  MEM stage has a load or store this cycle
- core_we  in  4  byte write enables from the store unit; 0 means load
- core_addr  in  ADDR_W  byte address (the MEM ALU result)
- core_wdata  in  32  store data, already lane-aligned
- core_stall  out  1  core request not serviced this cycle; core must hold all inputs
- core_rdata  out  32  pass-through of bram_do; valid the cycle after a granted core load
- host_valid  in  1  host request valid; held with all host fields until accepted
- host_write  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  byte address
- host_be  in  4  byte enables (writes only)
- host_wdata  in  32  write data
- host_ready  out  1  host request accepted this cycle (valid & ready = transfer)
- host_rvalid  out  1  one-cycle pulse; host_rdata holds read data
- host_rdata  out  32  registered read data; held until the next read response
- bram_we  out  4  port B byte write enables
- bram_addr  out  ADDR_W  port B address
- bram_di  out  32  port B write data
- bram_do  in  32  port B read data (1-cycle synchronous read)

## Operation
- Grant, combinational per cycle:
  - host_gnt = host_valid & (state==IDLE) & (!core_req | starve_cnt==STARVE_MAX)
  - core_gnt = core_req & !host_gnt
- Port B mux: when host_gnt, drive host_addr, host_wdata, and bram_we = host_write ? host_be : 4'b0. Otherwise drive the core fields, with bram_we = core_gnt ? core_we : 0.
  - bram_addr and bram_di follow the core fields when nobody is granted. Only bram_we matters in that case, and it is 0.
- core_stall = core_req & host_gnt. No other stall source.
- host_ready = host_gnt.
- starve_cnt, width $clog2(STARVE_MAX+1):
  - cleared on host_gnt, or when host_valid=0
  - incremented, saturating at STARVE_MAX, on host_valid & core_gnt & state==IDLE
  - otherwise held
- FSM:
  - IDLE: a host read grant goes to RD_WAIT. A host write or a core access stays in IDLE.
  - RD_WAIT, exactly one cycle: host_ready=0 and the core may use the port freely. bram_do (the host's data) is captured into host_rdata at the end of this cycle. host_rvalid is set. Return to IDLE.
- host_rvalid is high for exactly one cycle, the cycle after RD_WAIT. A new host request may be accepted in that same cycle.
- The core's load in RD_WAIT overwrites bram_do in the next cycle. This is harmless because host_rdata is already captured.

## Timing
- Reset values: state=IDLE, starve_cnt=0, host_rvalid=0, host_rdata=0.
  - While in reset, outputs are driven as in IDLE: bram_we=0 unless core_req, and a pending read is discarded.
  - Reset asserted in RD_WAIT: no host_rvalid is ever produced for that read.
- Core latency: a write is performed in the grant cycle. Load data appears on core_rdata in the next cycle, unchanged from the unarbitrated path.
- Host write: accepted in cycle N. The BRAM is updated at the clk edge ending N.
- Host read: accepted in N, RD_WAIT in N+1, host_rvalid=1 with data in N+2. At most one read is outstanding.
- Worst-case host wait under continuous core_req: STARVE_MAX+1 cycles from host_valid rising to host_ready.
- Core loses at most 1 cycle per STARVE_MAX+1 cycles under continuous host traffic.
- Simultaneous core_req and host_valid with starve_cnt<STARVE_MAX: the core wins, and the counter increments.

## Test plan
- Reset: assert rst mid-cycle with core_req=0 → host_rvalid=0, host_rdata=0, bram_we=0, host_ready=0 immediately (async).
- Core only: core_req=1, core_we=4'b1111, core_addr=0x100, core_wdata=0xDEADBEEF → bram_we=1111, bram_addr=0x100, bram_di=0xDEADBEEF, core_stall=0. A following load from 0x100 shows core_rdata=0xDEADBEEF one cycle later.
- Host read, idle core: preload 0x40=0x12345678. host_valid=1, host_write=0, host_addr=0x40 at cycle N → host_ready=1 at N, host_ready=0 at N+1, host_rvalid=1 and host_rdata=0x12345678 at N+2 only.
- Starvation, STARVE_MAX=4: core_req held 1 and host write held valid from cycle 0 → core granted cycles 0–3, host_ready=1 and core_stall=1 at cycle 4 only, core granted again at cycle 5 with starve_cnt=0.
- Byte enables: host write of 0xAABBCCDD with host_be=4'b0011 to a word holding 0x11223344 → bram_we=0011, the word reads back 0x1122CCDD.
- Reset during RD_WAIT: host read accepted at N, rst pulsed in N+1 → host_rvalid stays 0 through N+3. The FSM is in IDLE and accepts a new host read at the first cycle after rst deasserts.
